// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential 32-bit signed divider.
//   divState_e  : FSM state encoding (IDLE, ITER, FIX, DONE)
//   DIV_WIDTH   : operand / result width
//   DIV_STEPS   : number of non-restoring iterations
//   CNT_W       : iteration counter width
//   condNegate  : two's-complement negate on request, built as invert plus
//                 increment so it never needs the shared adder
// ---------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_e;

    function automatic logic [DIV_WIDTH-1:0] condNegate(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 negate
    );
        return negate ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/addsub_33b.sv
// ---------------------------------------------------------------------------
// addsub_33b
// Combinational 33-bit adder/subtractor: s = sub ? a - b : a + b.
// The lower 32 bits come from two 16-bit carry-lookahead cells; the top bit
// ripples off the upper cell's carry-out.
//   sub : 1 selects subtraction (b inverted, carry-in set)
//   a   : 33-bit first operand
//   b   : 33-bit second operand
//   s   : 33-bit result (carry-out discarded)
// Also contains cla16, the 16-bit carry-lookahead cell.
//   a_i, b_i : 16-bit operands      c_i : carry-in
//   s_o      : 16-bit sum           c_o : carry-out
// ---------------------------------------------------------------------------
module cla16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [16:0] carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Carry recurrence written per bit; synthesis flattens it into the
    // lookahead tree.
    always_comb begin
        carry    = '0;
        carry[0] = c_i;
        for (int i = 0; i < 16; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign s_o = prop ^ carry[15:0];
    assign c_o = carry[16];

endmodule

module addsub_33b (
    input  logic        sub,
    input  logic [32:0] a,
    input  logic [32:0] b,
    output logic [32:0] s
);

    logic [32:0] bEff;
    logic        carry16;
    logic        carry32;

    assign bEff = b ^ {33{sub}};

    cla16 uLow (
        .a_i (a[15:0]),
        .b_i (bEff[15:0]),
        .c_i (sub),
        .s_o (s[15:0]),
        .c_o (carry16)
    );

    cla16 uHigh (
        .a_i (a[31:16]),
        .b_i (bEff[31:16]),
        .c_i (carry16),
        .s_o (s[31:16]),
        .c_o (carry32)
    );

    assign s[32] = a[32] ^ bEff[32] ^ carry32;

endmodule

// File: rtl/div_32b_seq.sv
// ---------------------------------------------------------------------------
// div_32b_seq
// Sequential 32-bit signed non-restoring divider for the Mini SRC DIV
// instruction. One add/subtract step per clock on a 33-bit partial
// remainder, then a final correction and sign fix-up.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request a division (sampled only in IDLE)
//   dividend     : signed dividend (Ra), captured on acceptance
//   divisor      : signed divisor (Rb), captured on acceptance
//   busy         : operation in flight
//   done         : one-cycle pulse, results valid
//   quotient     : signed quotient (to LO)
//   remainder    : signed remainder (to HI)
//   div_by_zero  : divisor was zero for the current results
// ---------------------------------------------------------------------------
module div_32b_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    divState_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [32:0]        a_q, a_d;
    logic [31:0]        q_q, q_d;
    logic [32:0]        m_q, m_d;
    logic               negQuot_q, negQuot_d;
    logic               negRem_q, negRem_d;
    logic               zeroDiv_q, zeroDiv_d;
    logic [31:0]        quot_q, quot_d;
    logic [31:0]        rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [32:0]        aShift;
    logic               addSub;
    logic [32:0]        addA;
    logic [32:0]        addS;
    logic [32:0]        fixedA;

    // One adder serves both the ITER step (shifted A +/- M) and the FIX
    // correction (A + M); the operand mux depends only on registered state.
    assign aShift = {a_q[31:0], q_q[31]};
    assign addSub = (state_q == ITER) ? ~a_q[32] : 1'b0;
    assign addA   = (state_q == ITER) ? aShift : a_q;
    assign fixedA = a_q[32] ? addS : a_q;

    addsub_33b uAddSub (
        .sub (addSub),
        .a   (addA),
        .b   (m_q),
        .s   (addS)
    );

    // A zero divisor skips ITER and goes through FIX, where the flagged
    // results are written, so done still rises one cycle after acceptance.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        zeroDiv_d = zeroDiv_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    negQuot_d = dividend[31] ^ divisor[31];
                    negRem_d  = dividend[31];
                    count_d   = '0;
                    a_d       = '0;
                    if (divisor == '0) begin
                        zeroDiv_d = 1'b1;
                        q_d       = dividend;
                        m_d       = '0;
                        state_d   = FIX;
                    end else begin
                        zeroDiv_d = 1'b0;
                        q_d       = condNegate(dividend, dividend[31]);
                        m_d       = {1'b0, condNegate(divisor, divisor[31])};
                        state_d   = ITER;
                    end
                end
            end
            ITER: begin
                a_d     = addS;
                q_d     = {q_q[30:0], ~addS[32]};
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(DIV_STEPS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zeroDiv_q) begin
                    quot_d = '1;
                    rem_d  = q_q;
                    dbz_d  = 1'b1;
                end else begin
                    a_d    = fixedA;
                    quot_d = condNegate(q_q, negQuot_q);
                    rem_d  = condNegate(fixedA[31:0], negRem_q);
                    dbz_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and result registers; reset discards any in-flight division.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            zeroDiv_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            zeroDiv_q <= zeroDiv_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32b_seq.sv
// ---------------------------------------------------------------------------
// tb_div_32b_seq
// Self-checking bench for div_32b_seq. Expected results come from a 64-bit
// signed reference model, are queued when a division is requested and are
// popped when done pulses.
// ---------------------------------------------------------------------------
module tb_div_32b_seq;

    typedef struct {
        logic [31:0] quot;
        logic [31:0] rem;
        logic        dbz;
    } expect_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    expect_t     scoreboard[$];
    int          assertCount;
    int          failCount;
    int          latency;
    int          busyCycles;

    div_32b_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: truncating signed division in 64 bits, so the
    // -2^31 / -1 case wraps naturally when truncated back to 32 bits.
    function automatic expect_t refModel(input logic [31:0] a, input logic [31:0] b);
        expect_t e;
        longint  sa;
        longint  sbv;
        longint  q64;
        longint  r64;
        if (b == 32'd0) begin
            e.quot = 32'hFFFF_FFFF;
            e.rem  = a;
            e.dbz  = 1'b1;
        end else begin
            sa     = longint'($signed(a));
            sbv    = longint'($signed(b));
            q64    = sa / sbv;
            r64    = sa % sbv;
            e.quot = q64[31:0];
            e.rem  = r64[31:0];
            e.dbz  = 1'b0;
        end
        return e;
    endfunction

    // Single comparison point: counts every evaluation and every failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one start pulse at the current negedge and queue its expectation.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        scoreboard.push_back(refModel(a, b));
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Waits (bounded) for done; latency counts edges after acceptance.
    task automatic waitDone(output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        forever begin
            if (busy) busyCnt++;
            if (done || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        checkOutput("doneSeen", {31'd0, done}, 32'd1);
    endtask

    // Pops the oldest expectation and compares all three results.
    task automatic checkResult(input string tag);
        expect_t e;
        if (scoreboard.size() == 0) begin
            checkOutput({tag, ".scoreboardNonEmpty"}, 32'd0, 32'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({tag, ".quotient"}, quotient, e.quot);
            checkOutput({tag, ".remainder"}, remainder, e.rem);
            checkOutput({tag, ".divByZero"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end
    endtask

    // Full directed sequence of one division: start, wait, check.
    task automatic runDivision(input string tag, input logic [31:0] a, input logic [31:0] b);
        applyStimulus(a, b);
        waitDone(latency, busyCycles);
        checkResult(tag);
        @(negedge clk);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        dividend    = '0;
        divisor     = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.quotient", quotient, 32'd0);
        checkOutput("reset.remainder", remainder, 32'd0);
        checkOutput("reset.divByZero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with latency and busy-width checks.
        applyStimulus(32'd100, 32'd7);
        checkOutput("100div7.busyAfterAccept", {31'd0, busy}, 32'd1);
        waitDone(latency, busyCycles);
        checkOutput("100div7.latency", latency, 32'd33);
        checkResult("100div7");
        @(negedge clk);
        checkOutput("100div7.donePulse", {31'd0, done}, 32'd0);
        checkOutput("100div7.busyFall", {31'd0, busy}, 32'd0);
        checkOutput("100div7.busyCycles", busyCycles, 32'd34);
        checkOutput("100div7.holdQuot", quotient, 32'd14);

        // Sign combinations.
        runDivision("m7div2", 32'hFFFF_FFF9, 32'd2);
        runDivision("7divm2", 32'd7, 32'hFFFF_FFFE);
        runDivision("m7divm2", 32'hFFFF_FFF9, 32'hFFFF_FFFE);

        // Overflow wrap and all-ones dividend.
        runDivision("minDivM1", 32'h8000_0000, 32'hFFFF_FFFF);
        runDivision("m1div1", 32'hFFFF_FFFF, 32'd1);
        runDivision("bigDivSmall", 32'h7FFF_FFFF, 32'd3);

        // Divide by zero, then the flag must clear on the next divide.
        applyStimulus(32'd1234, 32'd0);
        waitDone(latency, busyCycles);
        checkOutput("div0.latency", latency, 32'd1);
        checkResult("div0");
        @(negedge clk);
        checkOutput("div0.donePulse", {31'd0, done}, 32'd0);
        checkOutput("div0.busyFall", {31'd0, busy}, 32'd0);
        runDivision("afterDiv0", 32'd55, 32'd4);

        // Start during ITER must be ignored.
        applyStimulus(32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd9;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0011;
        waitDone(latency, busyCycles);
        checkResult("ignoredStart");
        repeat (3) @(negedge clk);
        checkOutput("ignoredStart.staysIdle", {31'd0, busy}, 32'd0);

        // Start held high re-triggers in the IDLE cycle after done.
        dividend = 32'd77;
        divisor  = 32'hFFFF_FFFB;
        start    = 1'b1;
        scoreboard.push_back(refModel(32'd77, 32'hFFFF_FFFB));
        scoreboard.push_back(refModel(32'd77, 32'hFFFF_FFFB));
        @(negedge clk);
        waitDone(latency, busyCycles);
        checkResult("heldStart.first");
        @(negedge clk);
        checkOutput("heldStart.idleGap", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("heldStart.reaccept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        waitDone(latency, busyCycles);
        checkResult("heldStart.second");
        @(negedge clk);

        // Reset at ITER step 10 clears outputs with no clock edge.
        applyStimulus(32'd123456, 32'd7);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midReset.busy", {31'd0, busy}, 32'd0);
        checkOutput("midReset.done", {31'd0, done}, 32'd0);
        checkOutput("midReset.quotient", quotient, 32'd0);
        checkOutput("midReset.remainder", remainder, 32'd0);
        checkOutput("midReset.divByZero", {31'd0, div_by_zero}, 32'd0);
        void'(scoreboard.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runDivision("afterReset", 32'd50, 32'd5);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
